// File: rtl/rv32i_data_bus_if.sv
// Core load/store port plus slave-side select/strobe/ack bus of the data interconnect.
// The bus side drives requests and slave responses; the interconnect side drives the rest.
interface rv32i_data_bus_if #(
   parameter int NUM_SLV       = 4,
   parameter int SLV_ADDR_BITS = 12
);
   logic                       cpu_req;
   logic                       cpu_we;
   logic [31:0]                cpu_addr;
   logic [31:0]                cpu_wdata;
   logic [2:0]                 cpu_funct3;
   logic [31:0]                cpu_rdata;
   logic                       cpu_ready;
   logic                       cpu_err;
   logic [NUM_SLV-1:0]         slv_sel;
   logic                       slv_we;
   logic [SLV_ADDR_BITS-1:0]   slv_addr;
   logic [31:0]                slv_wdata;
   logic [3:0]                 slv_be;
   logic [NUM_SLV*32-1:0]      slv_rdata;
   logic [NUM_SLV-1:0]         slv_ack;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3, slv_rdata, slv_ack,
      input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, slv_be
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3, slv_rdata, slv_ack,
      output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata, slv_be
   );
endinterface

// File: rtl/rv32i_data_bus.sv
// RV32I data-side interconnect: decode, lane steering, load extension, ack/timeout handshake.
// Zero-wait slave gives cpu_ready 2 cycles after request; the core stalls until cpu_ready.
module rv32i_data_bus #(
   parameter int          NUM_SLV       = 4,
   parameter int          SLV_ADDR_BITS = 12,
   parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
   parameter int          TIMEOUT       = 15
) (
   input  logic clk,
   input  logic reset,
   rv32i_data_bus_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                   state_q, state_d;
   logic [NUM_SLV-1:0]       sel_q, sel_d;
   logic                     we_q, we_d;
   logic [SLV_ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [3:0]               be_q, be_d;
   logic [31:0]              rdata_q, rdata_d;
   logic                     ready_q, ready_d;
   logic                     err_q, err_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [2:0]               f3_q, f3_d;
   logic [1:0]               b_q, b_d;

   logic [31:0]        off, win, wdata_req, word, sh, load_ext;
   logic               in_range, size_ok;
   logic [1:0]         b;
   logic [3:0]         be_req;
   logic [NUM_SLV-1:0] sel_req;

   // Request decode; the unsigned compare against BASE_ADDR keeps low addresses from aliasing.
   always_comb begin
      off       = bus.cpu_addr - BASE_ADDR;
      win       = off >> SLV_ADDR_BITS;
      in_range  = (bus.cpu_addr >= BASE_ADDR) && (win < 32'(NUM_SLV));
      b         = bus.cpu_addr[1:0];
      size_ok   = 1'b0;
      be_req    = 4'b0000;
      wdata_req = 32'h0;
      case (bus.cpu_funct3)
         3'b000, 3'b100: begin
            size_ok   = 1'b1;
            be_req    = 4'b0001 << b;
            wdata_req = {4{bus.cpu_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            size_ok   = ~b[0];
            be_req    = 4'b0011 << b;
            wdata_req = {2{bus.cpu_wdata[15:0]}};
         end
         3'b010: begin
            size_ok   = (b == 2'b00);
            be_req    = 4'b1111;
            wdata_req = bus.cpu_wdata;
         end
         default: size_ok = 1'b0;
      endcase
      if (bus.cpu_we && bus.cpu_funct3[2]) size_ok = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) sel_req[i] = (win == 32'(i));
   end

   always_comb begin
      word = 32'h0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_q[i]) word = bus.slv_rdata[32*i +: 32];
      end
      sh       = word >> {b_q, 3'b000};
      load_ext = sh;
      case (f3_q)
         3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
         3'b100:  load_ext = {24'h0, sh[7:0]};
         3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
         3'b101:  load_ext = {16'h0, sh[15:0]};
         default: load_ext = sh;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      ready_d = ready_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'h0;
            cnt_d   = 8'h0;
            if (bus.cpu_req) begin
               if (in_range && size_ok) begin
                  state_d = ACCESS;
                  sel_d   = sel_req;
                  we_d    = bus.cpu_we;
                  addr_d  = {off[SLV_ADDR_BITS-1:2], 2'b00};
                  wdata_d = wdata_req;
                  be_d    = be_req;
                  f3_d    = bus.cpu_funct3;
                  b_d     = b;
               end else begin
                  state_d = RESP;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // An ack in the expiry cycle is checked first so it wins over the timeout.
            if (|(bus.slv_ack & sel_q) || (cnt_d == 8'(TIMEOUT))) begin
               state_d = RESP;
               ready_d = 1'b1;
               err_d   = ~|(bus.slv_ack & sel_q);
               rdata_d = (we_q || !(|(bus.slv_ack & sel_q))) ? 32'h0 : load_ext;
               sel_d   = '0;
               we_d    = 1'b0;
               addr_d  = '0;
               wdata_d = 32'h0;
               be_d    = 4'b0000;
            end
         end
         RESP: begin
            state_d = IDLE;
            ready_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'h0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         be_q    <= 4'b0000;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'h0;
         f3_q    <= 3'b000;
         b_q     <= 2'b00;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         b_q     <= b_d;
      end
   end

   assign bus.slv_sel   = sel_q;
   assign bus.slv_we    = we_q;
   assign bus.slv_addr  = addr_q;
   assign bus.slv_wdata = wdata_q;
   assign bus.slv_be    = be_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ready = ready_q;
   assign bus.cpu_err   = err_q;
endmodule

// File: tb/tb_rv32i_data_bus.sv
// Directed bench for rv32i_data_bus: acts as core and as the four slaves, checks against hand-computed values.
module tb_rv32i_data_bus;
   localparam int NS = 4;
   localparam int AB = 12;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   rv32i_data_bus_if #(.NUM_SLV(NS), .SLV_ADDR_BITS(AB)) bus ();

   rv32i_data_bus #(
      .NUM_SLV(NS), .SLV_ADDR_BITS(AB), .BASE_ADDR(32'h1000_0000), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [31:0]   r_rdata, r_wdata;
   logic          r_err, r_we;
   logic [NS-1:0] r_sel, r_sel_any, r_sel_rdy;
   logic [AB-1:0] r_addr;
   logic [3:0]    r_be;
   int            r_lat;

   // One core transaction; the selected slave acks in ACCESS cycle wt+1, or never when wt<0
   // (then every unselected slave acks instead).
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input int wt, input logic [31:0] word);
      int k;
      logic done;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
      bus.cpu_wdata = wd; bus.cpu_funct3 = f3; bus.slv_ack = '0;
      r_sel = '0; r_sel_any = '0; r_sel_rdy = '0; r_lat = -1;
      r_rdata = 32'hx; r_err = 1'bx; r_we = 1'bx; r_addr = 'x; r_wdata = 32'hx; r_be = 4'hx;
      done = 1'b0; k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
         bus.slv_ack = '0;
         if (bus.cpu_ready) begin
            done = 1'b1; r_lat = k; r_rdata = bus.cpu_rdata; r_err = bus.cpu_err;
            r_sel_rdy = bus.slv_sel; bus.cpu_req = 1'b0;
         end else if (bus.slv_sel != '0) begin
            if (r_sel == '0) begin
               r_sel = bus.slv_sel; r_we = bus.slv_we; r_addr = bus.slv_addr;
               r_wdata = bus.slv_wdata; r_be = bus.slv_be;
            end
            r_sel_any = r_sel_any | bus.slv_sel;
            for (int i = 0; i < NS; i++)
               bus.slv_rdata[32*i +: 32] = bus.slv_sel[i] ? word : (32'hA5A5_0000 | 32'(i));
            if (wt < 0) bus.slv_ack = ~bus.slv_sel;
            else if (k == wt + 1) bus.slv_ack = bus.slv_sel;
         end
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL xfer_no_ready: got no cpu_ready within %0d cycles, want one (addr %h)", k, addr);
      end
      bus.cpu_req = 1'b0; bus.slv_ack = '0;
   endtask

   task automatic test_reset();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
      bus.cpu_funct3 = 3'b000; bus.slv_ack = '0; bus.slv_rdata = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.cpu_ready, bus.cpu_err, bus.cpu_rdata, bus.slv_sel, bus.slv_we,
           bus.slv_addr, bus.slv_wdata, bus.slv_be} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h sel=%b be=%b, want all 0",
                  bus.cpu_ready, bus.cpu_err, bus.cpu_rdata, bus.slv_sel, bus.slv_be);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      xfer(1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 3'b010, 0, 32'h0);
      n_cmp++; if (r_sel !== 4'b0001) begin n_fail++; $display("FAIL sw_sel: got %b want 0001", r_sel); end
      n_cmp++; if (r_addr !== 12'h008) begin n_fail++; $display("FAIL sw_addr: got %h want 008", r_addr); end
      n_cmp++; if (r_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", r_be); end
      n_cmp++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", r_we); end
      n_cmp++; if (r_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", r_wdata); end
      n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
      n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", r_err); end
      n_cmp++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", r_rdata); end
      n_cmp++; if (r_sel_rdy !== 4'b0000) begin n_fail++; $display("FAIL sw_sel_in_resp: got %b want 0000", r_sel_rdy); end
      @(negedge clk);
      n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL ready_one_cycle: got %b want 0", bus.cpu_ready); end
      xfer(1'b0, 32'h1000_0008, 32'h0, 3'b010, 0, 32'hDEAD_BEEF);
      n_cmp++; if (r_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", r_rdata); end
      n_cmp++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", r_we); end
      n_cmp++; if (r_lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", r_lat); end
      // Three wait cycles stretch latency to 5.
      xfer(1'b0, 32'h1000_0010, 32'h0, 3'b010, 3, 32'h0BAD_F00D);
      n_cmp++; if (r_lat !== 5) begin n_fail++; $display("FAIL wait3_latency: got %0d want 5", r_lat); end
      n_cmp++; if (r_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wait3_rdata: got %h want 0badf00d", r_rdata); end
   endtask

   task automatic test_lanes();
      logic [31:0] addrs [6] = '{32'h1000_1003, 32'h1000_1003, 32'h1000_1002,
                                 32'h1000_1002, 32'h1000_1001, 32'h1000_1000};
      logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0,
                                 32'h0000_80F0, 32'h0000_007F, 32'h0000_7F01};
      logic [3:0]  bes   [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b0011};
      for (int i = 0; i < 6; i++) begin
         xfer(1'b0, addrs[i], 32'h0, f3s[i], 1, 32'h80F0_7F01);
         n_cmp++;
         if (r_rdata !== exps[i] || r_err !== 1'b0 || r_be !== bes[i] || r_sel !== 4'b0010) begin
            n_fail++;
            $display("FAIL load_lane%0d: got rdata=%h err=%b be=%b sel=%b want rdata=%h err=0 be=%b sel=0010",
                     i, r_rdata, r_err, r_be, r_sel, exps[i], bes[i]);
         end
      end
      xfer(1'b1, 32'h1000_1001, 32'h1234_56AB, 3'b000, 0, 32'h0);
      n_cmp++;
      if (r_be !== 4'b0010 || r_wdata !== 32'hABAB_ABAB || r_addr !== 12'h000 || r_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_lane: got be=%b wdata=%h addr=%h err=%b want be=0010 wdata=abababab addr=000 err=0",
                  r_be, r_wdata, r_addr, r_err);
      end
      xfer(1'b1, 32'h1000_1002, 32'hFFFF_1234, 3'b001, 0, 32'h0);
      n_cmp++;
      if (r_be !== 4'b1100 || r_wdata !== 32'h1234_1234) begin
         n_fail++;
         $display("FAIL sh_lane: got be=%b wdata=%h want be=1100 wdata=12341234", r_be, r_wdata);
      end
   endtask

   task automatic test_errors();
      logic        wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] addrs [6] = '{32'h1000_0002, 32'h1000_0001, 32'h1000_0000,
                                 32'h1000_0000, 32'h0FFF_FFFC, 32'h1000_4000};
      logic [2:0]  f3s   [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010};
      for (int i = 0; i < 6; i++) begin
         xfer(wes[i], addrs[i], 32'h5555_5555, f3s[i], 0, 32'h1111_1111);
         n_cmp++;
         if (r_err !== 1'b1 || r_lat !== 1 || r_sel_any !== 4'b0000 || r_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal%0d: got err=%b lat=%0d sel=%b rdata=%h want err=1 lat=1 sel=0000 rdata=0",
                     i, r_err, r_lat, r_sel_any, r_rdata);
         end
      end
      xfer(1'b0, 32'h1000_3FFC, 32'h0, 3'b010, 0, 32'h1234_5678);
      n_cmp++;
      if (r_sel !== 4'b1000 || r_addr !== 12'hFFC || r_err !== 1'b0 || r_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL last_window: got sel=%b addr=%h err=%b rdata=%h want sel=1000 addr=ffc err=0 rdata=12345678",
                  r_sel, r_addr, r_err, r_rdata);
      end
   endtask

   task automatic test_timeout();
      xfer(1'b0, 32'h1000_2004, 32'h0, 3'b010, -1, 32'h7777_7777);
      n_cmp++;
      if (r_err !== 1'b1 || r_lat !== TO + 1 || r_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL timeout: got err=%b lat=%0d rdata=%h want err=1 lat=%0d rdata=0",
                  r_err, r_lat, r_rdata, TO + 1);
      end
      xfer(1'b0, 32'h1000_2004, 32'h0, 3'b010, TO - 1, 32'h7777_7777);
      n_cmp++;
      if (r_err !== 1'b0 || r_lat !== TO + 1 || r_rdata !== 32'h7777_7777) begin
         n_fail++;
         $display("FAIL expiry_ack: got err=%b lat=%0d rdata=%h want err=0 lat=%0d rdata=77777777",
                  r_err, r_lat, r_rdata, TO + 1);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000_2000;
      bus.cpu_funct3 = 3'b010; bus.slv_ack = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.slv_sel !== 4'b0100) begin n_fail++; $display("FAIL pre_reset_sel: got %b want 0100", bus.slv_sel); end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.cpu_ready, bus.cpu_err, bus.cpu_rdata, bus.slv_sel, bus.slv_we, bus.slv_be} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got ready=%b sel=%b be=%b, want all 0", bus.cpu_ready, bus.slv_sel, bus.slv_be);
      end
      bus.cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.cpu_ready !== 1'b0 || bus.slv_sel !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle%0d: got ready=%b sel=%b want 0 0000", i, bus.cpu_ready, bus.slv_sel);
         end
      end
      xfer(1'b0, 32'h1000_2010, 32'h0, 3'b010, 1, 32'hCAFE_F00D);
      n_cmp++;
      if (r_err !== 1'b0 || r_lat !== 3 || r_rdata !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL after_reset_lw: got err=%b lat=%0d rdata=%h want err=0 lat=3 rdata=cafef00d",
                  r_err, r_lat, r_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_errors();
      test_timeout();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
